// File: rtl/interp_seq_if.sv
// Signal bundle between the triangle front end, the interpolator sequencer and the shading pipe.
// The slave side is the sequencer; the master side is its environment.
interface interp_seq_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [11:0] tile_x;
    logic [11:0] tile_y;
    logic [3:0]  param_count;
    logic [3:0]  param_sel;
    logic        setup;
    logic        coef_latch;
    logic [11:0] x_ps;
    logic [11:0] y_ps;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    modport slave (
        input  tri_valid, tile_x, tile_y, param_count, pix_ready,
        output tri_ready, param_sel, setup, coef_latch, x_ps, y_ps,
               pix_valid, pix_last, busy, done, dbg_state
    );

    modport master (
        output tri_valid, tile_x, tile_y, param_count, pix_ready,
        input  tri_ready, param_sel, setup, coef_latch, x_ps, y_ps,
               pix_valid, pix_last, busy, done, dbg_state
    );
endinterface

// File: rtl/interp_seq.sv
// Sequences plane-equation setup for each triangle parameter, then raster-scans one tile.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module interp_seq #(
    parameter int NUM_PARAMS    = 8,
    parameter int TILE_W        = 32,
    parameter int TILE_H        = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic      clock,
    input  logic      reset,
    interp_seq_if.slave bus
);

    localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(TILE_H - 1);
    localparam logic [SW-1:0] WAIT_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    NP_MAX    = 4'(NUM_PARAMS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_WAIT   = 3'd2,
        S_RASTER = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [11:0]   tx;
    logic [11:0]   ty;
    logic [3:0]    k_last;
    logic [3:0]    k;
    logic [SW-1:0] cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic          tri_ready_r;
    logic          busy_r;
    logic          done_r;
    logic          setup_r;
    logic          coef_r;
    logic          valid_r;
    logic          last_r;
    logic [11:0]   x_r;
    logic [11:0]   y_r;

    logic [3:0]    eff_last;
    logic [CW-1:0] col_nx;
    logic [RW-1:0] row_nx;
    logic          last_nx;

    // Index of the final parameter after clamping the request to 1..NUM_PARAMS.
    always_comb begin
        eff_last = 4'd0;
        if (bus.param_count == 4'd0)
            eff_last = 4'd0;
        else if (bus.param_count > NP_MAX)
            eff_last = NP_MAX - 4'd1;
        else
            eff_last = bus.param_count - 4'd1;
    end

    always_comb begin
        col_nx = col + CW'(1);
        row_nx = row;
        if (col == COL_MAX) begin
            col_nx = '0;
            row_nx = row + RW'(1);
        end
        last_nx = (col_nx == COL_MAX) && (row_nx == ROW_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            tx          <= '0;
            ty          <= '0;
            k_last      <= '0;
            k           <= '0;
            cnt         <= '0;
            col         <= '0;
            row         <= '0;
            tri_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            setup_r     <= 1'b0;
            coef_r      <= 1'b0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
        end else begin
            setup_r <= 1'b0;
            coef_r  <= 1'b0;
            done_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.tri_valid) begin
                        tx          <= bus.tile_x;
                        ty          <= bus.tile_y;
                        k_last      <= eff_last;
                        k           <= 4'd0;
                        setup_r     <= 1'b1;
                        tri_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= S_SEL;
                    end
                end
                S_SEL: begin
                    cnt    <= WAIT_LOAD;
                    coef_r <= (WAIT_LOAD == '0);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (k == k_last) begin
                            col     <= '0;
                            row     <= '0;
                            valid_r <= 1'b1;
                            x_r     <= tx;
                            y_r     <= ty;
                            last_r  <= (TILE_W == 1) && (TILE_H == 1);
                            state   <= S_RASTER;
                        end else begin
                            k       <= k + 4'd1;
                            setup_r <= 1'b1;
                            state   <= S_SEL;
                        end
                    end else begin
                        cnt    <= cnt - SW'(1);
                        coef_r <= (cnt == SW'(1));
                    end
                end
                S_RASTER: begin
                    if (bus.pix_ready) begin
                        if (last_r) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            col    <= col_nx;
                            row    <= row_nx;
                            x_r    <= tx + 12'(col_nx);
                            y_r    <= ty + 12'(row_nx);
                            last_r <= last_nx;
                        end
                    end
                end
                S_DONE: begin
                    tri_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tri_ready  = tri_ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.param_sel  = k;
    assign bus.setup      = setup_r;
    assign bus.coef_latch = coef_r;
    assign bus.pix_valid  = valid_r;
    assign bus.pix_last   = last_r;
    assign bus.x_ps       = x_r;
    assign bus.y_ps       = y_r;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_interp_seq.sv
// Bench for interp_seq: a default 32x32 instance and a small 4x2 instance, both checked
// against a cycle-accurate schedule and pixel list computed from the sequencing rules.
module tb_interp_seq;
  localparam int S = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        tri_valid;
  logic [11:0] tile_x;
  logic [11:0] tile_y;
  logic [3:0]  param_count;
  logic        pix_ready;
  int          cur;

  interp_seq_if if_a ();
  interp_seq_if if_b ();

  assign if_a.tri_valid   = tri_valid && (cur == 0);
  assign if_b.tri_valid   = tri_valid && (cur == 1);
  assign if_a.tile_x      = tile_x;
  assign if_b.tile_x      = tile_x;
  assign if_a.tile_y      = tile_y;
  assign if_b.tile_y      = tile_y;
  assign if_a.param_count = param_count;
  assign if_b.param_count = param_count;
  assign if_a.pix_ready   = pix_ready;
  assign if_b.pix_ready   = pix_ready;

  interp_seq dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a)
  );

  interp_seq #(
    .NUM_PARAMS    (8),
    .TILE_W        (4),
    .TILE_H        (2),
    .SETTLE_CYCLES (4)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b)
  );

  // observed outputs of the instance under test
  logic        o_tri_ready, o_busy, o_done, o_setup, o_coef, o_valid, o_last;
  logic [3:0]  o_sel;
  logic [11:0] o_x, o_y;

  always_comb begin
    o_tri_ready = if_a.tri_ready;
    o_busy      = if_a.busy;
    o_done      = if_a.done;
    o_setup     = if_a.setup;
    o_coef      = if_a.coef_latch;
    o_valid     = if_a.pix_valid;
    o_last      = if_a.pix_last;
    o_sel       = if_a.param_sel;
    o_x         = if_a.x_ps;
    o_y         = if_a.y_ps;
    if (cur == 1) begin
      o_tri_ready = if_b.tri_ready;
      o_busy      = if_b.busy;
      o_done      = if_b.done;
      o_setup     = if_b.setup;
      o_coef      = if_b.coef_latch;
      o_valid     = if_b.pix_valid;
      o_last      = if_b.pix_last;
      o_sel       = if_b.param_sel;
      o_x         = if_b.x_ps;
      o_y         = if_b.y_ps;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d observed=0x%0h expected=0x%0h at %0t", tag, cur, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tri_ready"}, o_tri_ready, 1);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_pix_valid"}, o_valid, 0);
    check_eq({tag, "_setup"}, o_setup, 0);
    check_eq({tag, "_coef"}, o_coef, 0);
  endtask

  // Starts at a falling edge with the instance idle; returns at a falling edge.
  // mode: 0 ready tied high, 1 ready toggling 1,0,1,0..., 2 random ready.
  task automatic run_tri(input int tx, input int ty, input int pc, input int mode,
                         input int abort_after, output bit aborted);
    logic [24:0] exp_q[$];
    int p, w, h, first_pix, last_cyc, hs, setups, budget, exp_sel;
    bit fin, ready, l;
    w = (cur == 1) ? 4 : 32;
    h = (cur == 1) ? 2 : 32;
    p = (pc == 0) ? 1 : ((pc > 8) ? 8 : pc);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        l = (r == h - 1) && (c == w - 1);
        exp_q.push_back({l, 12'((ty + r) % 4096), 12'((tx + c) % 4096)});
      end
    end
    first_pix = p * (1 + S) + 1;
    budget    = first_pix + 20 * w * h + 100;
    last_cyc  = -1;
    hs        = 0;
    setups    = 0;
    aborted   = 0;
    fin       = 0;

    check_eq("accept_ready", o_tri_ready, 1);
    tile_x      = 12'(tx);
    tile_y      = 12'(ty);
    param_count = 4'(pc);
    tri_valid   = 1'b1;
    @(posedge clock);

    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      @(negedge clock);
      tri_valid   = 1'b0;
      tile_x      = 12'($urandom);
      tile_y      = 12'($urandom);
      param_count = 4'($urandom);
      if (last_cyc >= 0 && cyc == last_cyc + 2) begin
        check_idle("after_done");
        fin = 1;
      end else if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        check_eq("done_pulse", o_done, 1);
        check_eq("done_pix_valid", o_valid, 0);
        check_eq("done_busy", o_busy, 1);
        check_eq("done_tri_ready", o_tri_ready, 0);
      end else begin
        check_eq("busy", o_busy, 1);
        check_eq("tri_ready_busy", o_tri_ready, 0);
        check_eq("done_early", o_done, 0);
        check_eq("setup", o_setup, (cyc < first_pix) && ((cyc - 1) % (S + 1) == 0));
        check_eq("coef_latch", o_coef, (cyc < first_pix) && (cyc % (S + 1) == 0));
        if (o_setup) setups++;
        exp_sel = (cyc < first_pix) ? (cyc - 1) / (S + 1) : p - 1;
        check_eq("param_sel", o_sel, exp_sel);
        check_eq("pix_valid", o_valid, cyc >= first_pix);
        if (cyc >= first_pix && exp_q.size() > 0) begin
          check_eq("pixel", {7'd0, o_last, o_y, o_x}, {7'd0, exp_q[0]});
          case (mode)
            0:       ready = 1'b1;
            1:       ready = ((cyc - first_pix) % 2 == 0);
            default: ready = 1'($urandom_range(0, 1));
          endcase
          pix_ready = ready;
          if (ready) begin
            void'(exp_q.pop_front());
            hs++;
            if (exp_q.size() == 0) last_cyc = cyc;
            if (abort_after > 0 && hs == abort_after) begin
              aborted = 1;
              return;
            end
          end
        end else begin
          pix_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!fin) check_eq("timeout", 0, 1);
    else check_eq("setup_count", setups, p);
  endtask

  bit ab;

  initial begin
    cur         = 0;
    tri_valid   = 1'b0;
    tile_x      = '0;
    tile_y      = '0;
    param_count = '0;
    pix_ready   = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      cur = d;
      repeat (2) @(negedge clock);
      check_idle("reset");
      check_eq("reset_pix_last", o_last, 0);
      check_eq("reset_x", o_x, 0);
      check_eq("reset_y", o_y, 0);
      check_eq("reset_sel", o_sel, 0);
    end

    cur = 0;
    run_tri(64, 32, 3, 0, 0, ab);
    run_tri(100, 200, 0, 2, 0, ab);
    run_tri(8, 16, 15, 2, 0, ab);
    run_tri(4080, 4090, 2, 0, 0, ab);

    cur = 1;
    @(negedge clock);
    run_tri(5, 7, 1, 1, 0, ab);
    for (int i = 0; i < 6; i++)
      run_tri(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 15)), 2, 0, ab);

    // reset in the middle of a raster with a request already waiting
    cur = 0;
    @(negedge clock);
    run_tri(300, 400, 1, 0, 10, ab);
    check_eq("abort_reached", ab, 1);
    reset       = 1'b1;
    tri_valid   = 1'b1;
    tile_x      = 12'd500;
    tile_y      = 12'd600;
    param_count = 4'd2;
    @(posedge clock);
    @(negedge clock);
    check_idle("mid_reset");
    check_eq("mid_reset_pix_last", o_last, 0);
    reset = 1'b0;
    run_tri(500, 600, 2, 0, 0, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interp_seq.md
Name: interp_seq

Overview:
- Sequences the shared plane-equation interpolator for one triangle within one screen tile.
- For each triangle parameter (Z, U, V, colour, ...), in turn:
  - selects that parameter's vertex values onto the interpolator inputs;
  - holds them for a fixed settle time, then tells the coefficient store to capture the plane coefficients.
- It then raster-scans the tile and drives the interpolator's pixel coordinates with a valid/ready handshake.
- Sits between the triangle fetch/setup front end and the per-pixel shading pipe.

Parameters:
- NUM_PARAMS, 8: maximum parameters per triangle. Range 1..15.
- TILE_W, 32: tile width in pixels. Power of two, 1..64.
- TILE_H, 32: tile height in pixels. Power of two, 1..64.
- SETTLE_CYCLES, 4: cycles the interpolator setup path is given to settle after a selection change. Minimum 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- tri_valid  in  1  triangle request
- tri_ready  out  1  high only in IDLE
- tile_x  in  12  tile origin X, captured on accept
- tile_y  in  12  tile origin Y, captured on accept
- param_count  in  4  parameters for this triangle, captured on accept
- param_sel  out  4  index of the parameter currently presented to the interpolator
- setup  out  1  one-cycle pulse when param_sel takes a new value
- coef_latch  out  1  one-cycle pulse: capture coefficients for param_sel
- x_ps  out  12  pixel X = tile origin X + column
- y_ps  out  12  pixel Y = tile origin Y + row
- pix_valid  out  1  pixel coordinate valid
- pix_ready  in  1  downstream accepts pixel
- pix_last  out  1  qualifies the final pixel of the tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset values: state=IDLE, tri_ready=1, busy=0, param_sel=0, setup=0, coef_latch=0, pix_valid=0, pix_last=0, done=0, x_ps=0, y_ps=0. Internal counters are cleared.
- Reset takes effect from any state, including mid-raster. No pixel or done pulse follows it.
- States: IDLE, SEL, WAIT, RASTER, DONE.
- IDLE:
  - A triangle is accepted when tri_valid && tri_ready. That edge captures tile_x, tile_y and param_count.
  - Effective count P = clamp(param_count, 1, NUM_PARAMS); a value of 0 is treated as 1.
  - Next state: SEL with k=0.
- SEL (1 cycle): param_sel=k, setup=1. Next state: WAIT with the wait counter loaded to SETTLE_CYCLES-1.
- WAIT (SETTLE_CYCLES cycles):
  - param_sel is held; the counter decrements.
  - coef_latch=1 in the cycle the counter is 0.
  - From that cycle: if k==P-1, go to RASTER with col=0, row=0; otherwise k=k+1 and go to SEL.
- Latency: counting the accept edge as cycle 0:
  - SEL for parameter k is at cycle 1+k*(1+SETTLE_CYCLES).
  - coef_latch for parameter k is at cycle (k+1)*(1+SETTLE_CYCLES).
  - The first pix_valid is at cycle P*(1+SETTLE_CYCLES)+1.
- RASTER:
  - Outputs: pix_valid=1, x_ps=(tile_x+col) mod 4096, y_ps=(tile_y+row) mod 4096. 12-bit wrap-around is intentional; no saturation.
  - Scan order is row-major: col increments; at col==TILE_W-1 col wraps to 0 and row increments.
  - Advance happens only when pix_valid && pix_ready. While pix_ready=0, x_ps, y_ps and pix_last hold stable.
  - pix_last=1 exactly when col==TILE_W-1 && row==TILE_H-1.
  - The handshake on the last pixel moves to DONE; pix_valid drops the next cycle.
- DONE (1 cycle): done=1, busy=1, tri_ready=0. Next state: IDLE.
- A new triangle cannot be accepted in DONE, so the minimum gap between accepts is set by the full sequence.
- param_sel holds its last value outside SEL/WAIT. Inputs tile_x, tile_y and param_count are ignored outside the accept edge.
- setup and coef_latch are never high in the same cycle. pix_valid is never high outside RASTER.

Test Plan:
- Reset, then idle with no request:
  - Required: tri_ready=1, busy=0, all pulses 0, x_ps=y_ps=0.
- Defaults, P=3, tile (64,32), pix_ready tied 1:
  - setup at cycles 1, 6, 11; coef_latch at 5, 10, 15 with param_sel 0, 1, 2.
  - First pixel (64,32) at cycle 16; pix_last on (95,63) at cycle 1039; done at 1040; tri_ready=1 at 1041.
- TILE_W=4, TILE_H=2, P=1, pix_ready toggling 1,0,1,0:
  - Exactly 8 handshakes, in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
  - Outputs stable across stalled cycles; pix_last only on (3,1).
- param_count=0, then param_count=15 with NUM_PARAMS=8:
  - Exactly 1 and exactly 8 setup pulses respectively.
- tile_x=4080, TILE_W=32: x_ps runs 4080..4095 then wraps 0..15 on each row.
- Reset asserted mid-RASTER (after 10 pixels), tri_valid held high:
  - Next cycle state is IDLE, pix_valid=0, no done pulse.
  - The following triangle is accepted and restarts at param_sel=0, pixel (tile_x, tile_y).
